// File: rtl/qracc_pkg.sv
// Shared types and constants for the QRACC SRAM bridge.
//
// Contents:
//   DefaultTimeout - default read-data timeout in cycles
//   BusAddrWidth   - upstream bus address width
//   WordWidth      - data word width on both sides
//   CntWidth       - width of the read-timeout cycle counter
//   bridge_state_t - bridge FSM state encoding
package qracc_pkg;

    localparam int unsigned DefaultTimeout = 255;
    localparam int unsigned BusAddrWidth   = 32;
    localparam int unsigned WordWidth      = 32;
    localparam int unsigned CntWidth       = 8;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitRd,
        StResp
    } bridge_state_t;

endpackage

// File: rtl/qracc_sram_bridge_if.sv
// Bus interfaces used by the QRACC SRAM bridge.
//
// qracc_data_interface: upstream request/response bus.
//   master drives data_in, addr, wen, valid; slave drives ready, data_out, rd_data_valid.
// sram_itf: downstream SRAM request/read-data channel.
//   master drives rq_wr_i, rq_valid_i, wr_data_i, addr_i;
//   slave drives rq_ready_o, rd_valid_o, rd_data_o.
interface qracc_data_interface #(
    parameter int unsigned AddrWidth = qracc_pkg::BusAddrWidth,
    parameter int unsigned DataWidth = qracc_pkg::WordWidth
);
    logic [DataWidth-1:0] data_in;
    logic [AddrWidth-1:0] addr;
    logic                 wen;
    logic                 valid;
    logic                 ready;
    logic [DataWidth-1:0] data_out;
    logic                 rd_data_valid;

    modport master (
        output data_in, addr, wen, valid,
        input  ready, data_out, rd_data_valid
    );

    modport slave (
        input  data_in, addr, wen, valid,
        output ready, data_out, rd_data_valid
    );
endinterface

interface sram_itf #(
    parameter int unsigned AddrWidth = 7,
    parameter int unsigned DataWidth = qracc_pkg::WordWidth
);
    logic                 rq_wr_i;
    logic                 rq_valid_i;
    logic [DataWidth-1:0] wr_data_i;
    logic [AddrWidth-1:0] addr_i;
    logic                 rq_ready_o;
    logic                 rd_valid_o;
    logic [DataWidth-1:0] rd_data_o;

    modport master (
        output rq_wr_i, rq_valid_i, wr_data_i, addr_i,
        input  rq_ready_o, rd_valid_o, rd_data_o
    );

    modport slave (
        input  rq_wr_i, rq_valid_i, wr_data_i, addr_i,
        output rq_ready_o, rd_valid_o, rd_data_o
    );
endinterface

// File: rtl/qracc_sram_bridge.sv
// Bridge from the QRACC upstream data bus to a single-port SRAM request channel.
// One transaction at a time: accept, issue SRAM request, optionally wait for read
// data (with timeout), then a one-cycle response before accepting the next one.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   bus   - upstream slave port (data_in/addr/wen/valid in; ready/data_out/rd_data_valid out)
//   sram  - downstream master port (request out; ready/read data in)
//   err_o - one-cycle pulse when a transaction ends out-of-range or on read timeout
module qracc_sram_bridge
    import qracc_pkg::*;
#(
    parameter int unsigned numRows       = 128,
    parameter int unsigned numCols       = 32,
    parameter int unsigned timeoutCycles = DefaultTimeout
) (
    input  logic                clk,
    input  logic                rst,
    qracc_data_interface.slave  bus,
    sram_itf.master             sram,
    output logic                err_o
);

    localparam int unsigned AddrW = (numRows > 1) ? $clog2(numRows) : 1;
    localparam logic [CntWidth-1:0] TimeoutCnt = CntWidth'(timeoutCycles - 1);

    bridge_state_t        state_q;
    logic [AddrW-1:0]     addr_q;
    logic [numCols-1:0]   data_q;
    logic                 wen_q;
    logic                 err_flag_q;
    logic [CntWidth-1:0]  cnt_q;
    logic [numCols-1:0]   data_out_q;
    logic                 rq_valid_q;
    logic                 rd_data_valid_q;
    logic                 in_range;

    assign in_range = (bus.addr < BusAddrWidth'(numRows));

    assign bus.ready         = (state_q == StIdle);
    assign bus.data_out      = data_out_q;
    assign bus.rd_data_valid = rd_data_valid_q;

    assign sram.rq_valid_i = rq_valid_q;
    assign sram.rq_wr_i    = wen_q;
    assign sram.addr_i     = addr_q;
    assign sram.wr_data_i  = data_q;

    // Error flag is held for the whole transaction; only exposed during RESP.
    assign err_o = (state_q == StResp) && err_flag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            data_q          <= '0;
            wen_q           <= 1'b0;
            err_flag_q      <= 1'b0;
            cnt_q           <= '0;
            data_out_q      <= '0;
            rq_valid_q      <= 1'b0;
            rd_data_valid_q <= 1'b0;
        end else begin
            rd_data_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.valid) begin
                        addr_q <= bus.addr[AddrW-1:0];
                        data_q <= bus.data_in;
                        wen_q  <= bus.wen;
                        cnt_q  <= '0;
                        if (in_range) begin
                            err_flag_q <= 1'b0;
                            rq_valid_q <= 1'b1;
                            state_q    <= StReq;
                        end else begin
                            // Out-of-range: no SRAM request; reads return zero.
                            err_flag_q <= 1'b1;
                            state_q    <= StResp;
                            if (!bus.wen) begin
                                data_out_q      <= '0;
                                rd_data_valid_q <= 1'b1;
                            end
                        end
                    end
                end
                StReq: begin
                    if (sram.rq_ready_o) begin
                        rq_valid_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= wen_q ? StResp : StWaitRd;
                    end
                end
                StWaitRd: begin
                    // Read data beats the timeout when both land on the same cycle.
                    if (sram.rd_valid_o) begin
                        data_out_q      <= sram.rd_data_o;
                        rd_data_valid_q <= 1'b1;
                        state_q         <= StResp;
                    end else if (cnt_q == TimeoutCnt) begin
                        data_out_q      <= '0;
                        err_flag_q      <= 1'b1;
                        rd_data_valid_q <= 1'b1;
                        state_q         <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qracc_sram_bridge.sv
// Self-checking bench for qracc_sram_bridge: directed transactions, an SRAM
// responder with configurable stall/read delay, and a reference model of the
// expected SRAM requests and bus responses (with their cycle of arrival).
module tb_qracc_sram_bridge;
    import qracc_pkg::*;

    localparam int unsigned NumRows = 128;
    localparam int          Timeout = 255;
    localparam int          Never   = -1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_o;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    qracc_data_interface bus_if ();
    sram_itf #(.AddrWidth(7)) sram_if ();

    qracc_sram_bridge #(
        .numRows      (NumRows),
        .numCols      (32),
        .timeoutCycles(Timeout)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if),
        .sram (sram_if),
        .err_o(err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        bit          err;
        int          cycle;
    } resp_t;

    typedef struct {
        bit          wr;
        logic [6:0]  addr;
        logic [31:0] data;
    } req_t;

    resp_t       resp_q[$];
    req_t        req_q[$];
    logic [31:0] ref_mem [NumRows];
    logic [31:0] sram_mem[NumRows];
    logic [31:0] exp_dout = 32'h0;
    int          stall_n = 0;
    int          rd_delay = 1;
    int          spurious_n = 0;
    int          hs_count = 0;
    int          rdv_count = 0;
    int          err_count = 0;
    int          last_evt_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // SRAM responder: stalls rq_ready_o for stall_n cycles, returns read data
    // rd_delay cycles after the handshake (never if rd_delay < 1).
    initial begin : sram_model
        bit         pend;
        int         rd_at;
        logic [6:0] rd_addr;
        int         wait_cnt;
        bit         r;
        pend = 0; rd_at = 0; rd_addr = '0; wait_cnt = 0;
        sram_if.rq_ready_o = 1'b0;
        sram_if.rd_valid_o = 1'b0;
        sram_if.rd_data_o  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0;
                wait_cnt = 0;
                sram_if.rq_ready_o = 1'b0;
                sram_if.rd_valid_o = 1'b0;
            end else begin
                r = (stall_n == 0) || (sram_if.rq_valid_i && wait_cnt >= stall_n);
                if (sram_if.rq_valid_i && !r) wait_cnt++;
                sram_if.rq_ready_o = r;
                if (sram_if.rq_valid_i && r) begin
                    hs_count++;
                    wait_cnt = 0;
                    if (sram_if.rq_wr_i) begin
                        sram_mem[sram_if.addr_i] = sram_if.wr_data_i;
                    end else if (rd_delay >= 1) begin
                        pend = 1;
                        rd_at = cyc + rd_delay;
                        rd_addr = sram_if.addr_i;
                    end
                end
                if (pend && cyc == rd_at) begin
                    pend = 0;
                    sram_if.rd_valid_o = 1'b1;
                    sram_if.rd_data_o  = sram_mem[rd_addr];
                end else if (spurious_n > 0) begin
                    spurious_n--;
                    sram_if.rd_valid_o = 1'b1;
                    sram_if.rd_data_o  = 32'hDEAD_BEEF;
                end else begin
                    sram_if.rd_valid_o = 1'b0;
                end
            end
        end
    end

    // Compare process: SRAM requests, request stability, responses and data_out hold.
    initial begin : monitor
        bit          pv, pr, pw;
        logic [6:0]  pa;
        logic [31:0] pd;
        resp_t       e;
        req_t        q;
        pv = 0; pr = 0; pw = 0; pa = '0; pd = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pv = 0;
            end else begin
                if (pv && !pr && sram_if.rq_valid_i) begin
                    chk("req_addr_stable", 32'(sram_if.addr_i), 32'(pa));
                    chk("req_data_stable", sram_if.wr_data_i, pd);
                    chk("req_wr_stable", 32'(sram_if.rq_wr_i), 32'(pw));
                end
                if (sram_if.rq_valid_i && sram_if.rq_ready_o) begin
                    if (req_q.size() == 0) begin
                        fail_now("unexpected_sram_request");
                    end else begin
                        q = req_q.pop_front();
                        chk("req_wr", 32'(sram_if.rq_wr_i), 32'(q.wr));
                        chk("req_addr", 32'(sram_if.addr_i), 32'(q.addr));
                        if (q.wr) chk("req_wdata", sram_if.wr_data_i, q.data);
                    end
                end
                pv = sram_if.rq_valid_i; pr = sram_if.rq_ready_o;
                pa = sram_if.addr_i; pd = sram_if.wr_data_i; pw = sram_if.rq_wr_i;

                if (bus_if.rd_data_valid || err_o) begin
                    last_evt_cyc = cyc;
                    if (bus_if.rd_data_valid) rdv_count++;
                    if (err_o) err_count++;
                    if (resp_q.size() == 0) begin
                        fail_now("unexpected_response");
                    end else begin
                        e = resp_q.pop_front();
                        chk("resp_cycle", cyc, e.cycle);
                        chk("resp_rd_data_valid", 32'(bus_if.rd_data_valid), 32'(e.is_read));
                        chk("resp_err", 32'(err_o), 32'(e.err));
                        if (e.is_read) begin
                            chk("resp_data", bus_if.data_out, e.data);
                            exp_dout = e.data;
                        end
                    end
                end else begin
                    chk("data_out_hold", bus_if.data_out, exp_dout);
                    if (resp_q.size() > 0 && cyc > resp_q[0].cycle) begin
                        fail_now("missing_response");
                        void'(resp_q.pop_front());
                    end
                end
            end
        end
    end

    // Issue one transaction and push the model's expectations.
    task automatic txn(input logic [31:0] a, input logic [31:0] d, input bit w,
                       input int stall, input int delay, input bit wait_done,
                       output int t_acc, output int ready_lat);
        int    n;
        int    h;
        resp_t e;
        req_t  q;
        stall_n = stall;
        rd_delay = delay;
        ready_lat = -1;
        @(negedge clk);
        bus_if.addr = a; bus_if.data_in = d; bus_if.wen = w; bus_if.valid = 1'b1;
        n = 0;
        while (!bus_if.ready && n < 1000) begin @(negedge clk); n++; end
        t_acc = cyc;
        if (!bus_if.ready) begin
            fail_now("accept_timeout");
            bus_if.valid = 1'b0;
            return;
        end
        if (a >= NumRows) begin
            e = '{is_read: !w, data: 32'h0, err: 1'b1, cycle: t_acc + 1};
            resp_q.push_back(e);
        end else begin
            q = '{wr: w, addr: a[6:0], data: d};
            req_q.push_back(q);
            h = t_acc + 1 + stall;
            if (w) begin
                ref_mem[a[6:0]] = d;
            end else if (delay >= 1 && delay <= Timeout) begin
                e = '{is_read: 1'b1, data: ref_mem[a[6:0]], err: 1'b0, cycle: h + delay + 1};
                resp_q.push_back(e);
            end else begin
                e = '{is_read: 1'b1, data: 32'h0, err: 1'b1, cycle: h + Timeout + 1};
                resp_q.push_back(e);
            end
        end
        @(negedge clk);
        bus_if.valid = 1'b0;
        if (wait_done) begin
            n = 1;
            while (!bus_if.ready && n < 1000) begin @(negedge clk); n++; end
            if (bus_if.ready) ready_lat = cyc - t_acc;
            else fail_now("done_timeout");
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin : main
        int t, lat, hs0, rdv0, err0;
        bus_if.addr = '0; bus_if.data_in = '0; bus_if.wen = 1'b0; bus_if.valid = 1'b0;
        for (int i = 0; i < NumRows; i++) begin
            ref_mem[i]  = 32'hC0DE_0000 | 32'(i);
            sram_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus_if.ready), 32'd1);
        chk("rst_rq_valid", 32'(sram_if.rq_valid_i), 32'd0);
        chk("rst_rd_data_valid", 32'(bus_if.rd_data_valid), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_data_out", bus_if.data_out, 32'h0);
        rst = 1'b0;

        // Write addr 5, ready tied high.
        hs0 = hs_count; err0 = err_count;
        txn(32'd5, 32'hA5A5_1234, 1'b1, 0, 1, 1'b1, t, lat);
        chk("wr_ready_latency", lat, 32'd3);
        chk("wr_one_handshake", hs_count - hs0, 32'd1);
        chk("wr_sram_content", sram_mem[5], 32'hA5A5_1234);
        chk("wr_no_err", err_count - err0, 32'd0);

        // Read addr 5 with data three cycles after the handshake.
        rdv0 = rdv_count;
        txn(32'd5, 32'h0, 1'b0, 0, 3, 1'b1, t, lat);
        chk("rd_data_literal", bus_if.data_out, 32'hA5A5_1234);
        chk("rd_single_pulse", rdv_count - rdv0, 32'd1);
        chk("rd_delay3_latency", last_evt_cyc - t, 32'd5);

        // Minimum read latency.
        txn(32'd5, 32'h0, 1'b0, 0, 1, 1'b1, t, lat);
        chk("rd_min_latency", last_evt_cyc - t, 32'd3);

        // Write with rq_ready_o held low for 10 cycles.
        hs0 = hs_count;
        txn(32'd9, 32'h1357_9BDF, 1'b1, 10, 1, 1'b1, t, lat);
        chk("stall_one_handshake", hs_count - hs0, 32'd1);
        chk("stall_ready_latency", lat, 32'd13);

        // Assorted patterns, including the last valid row.
        txn(32'd0, 32'hFFFF_FFFF, 1'b1, 0, 1, 1'b1, t, lat);
        txn(32'd127, 32'h0000_0001, 1'b1, 1, 1, 1'b1, t, lat);
        txn(32'd127, 32'h0, 1'b0, 0, 2, 1'b1, t, lat);
        chk("rd_row127", bus_if.data_out, 32'h0000_0001);
        txn(32'd0, 32'h0, 1'b0, 2, 5, 1'b1, t, lat);
        chk("rd_row0_latency", last_evt_cyc - t, 32'd9);
        txn(32'd64, 32'h0, 1'b0, 0, 1, 1'b1, t, lat);
        chk("rd_unwritten_row", bus_if.data_out, 32'hC0DE_0040);

        // Out-of-range write and read.
        hs0 = hs_count; err0 = err_count;
        txn(32'd128, 32'h1111_2222, 1'b1, 0, 1, 1'b1, t, lat);
        chk("oor_wr_ready_latency", lat, 32'd2);
        txn(32'd200, 32'h0, 1'b0, 0, 1, 1'b1, t, lat);
        chk("oor_no_request", hs_count - hs0, 32'd0);
        chk("oor_err_pulses", err_count - err0, 32'd2);
        chk("oor_rd_data", bus_if.data_out, 32'h0);

        // Read timeout.
        txn(32'd0, 32'h0, 1'b0, 0, 1, 1'b1, t, lat);
        err0 = err_count;
        txn(32'd9, 32'h0, 1'b0, 0, Never, 1'b1, t, lat);
        chk("timeout_latency", last_evt_cyc - t, 32'd257);
        chk("timeout_data", bus_if.data_out, 32'h0);
        chk("timeout_err", err_count - err0, 32'd1);

        // Data on the timeout cycle wins; one cycle later it is too late and ignored.
        err0 = err_count;
        txn(32'd9, 32'h0, 1'b0, 0, 255, 1'b1, t, lat);
        chk("tie_latency", last_evt_cyc - t, 32'd257);
        chk("tie_data", bus_if.data_out, 32'h1357_9BDF);
        chk("tie_no_err", err_count - err0, 32'd0);
        txn(32'd9, 32'h0, 1'b0, 0, 256, 1'b1, t, lat);
        chk("late_data_timeout", bus_if.data_out, 32'h0);
        repeat (3) @(negedge clk);

        // rd_valid_o while idle is ignored.
        rdv0 = rdv_count;
        spurious_n = 2;
        repeat (4) @(negedge clk);
        chk("idle_rd_valid_ignored", rdv_count - rdv0, 32'd0);

        // Reset while waiting for read data.
        txn(32'd0, 32'h0, 1'b0, 0, 1, 1'b1, t, lat);
        txn(32'd5, 32'h0, 1'b0, 0, Never, 1'b0, t, lat);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        resp_q.delete();
        req_q.delete();
        exp_dout = 32'h0;
        #1;
        chk("midrst_ready", 32'(bus_if.ready), 32'd1);
        chk("midrst_rq_valid", 32'(sram_if.rq_valid_i), 32'd0);
        chk("midrst_data_out", bus_if.data_out, 32'h0);
        chk("midrst_err", 32'(err_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus_if.ready), 32'd1);
        rdv0 = rdv_count;
        spurious_n = 1;
        repeat (3) @(negedge clk);
        chk("post_rst_rd_valid_ignored", rdv_count - rdv0, 32'd0);
        txn(32'd127, 32'h0, 1'b0, 0, 1, 1'b1, t, lat);
        chk("post_rst_read", bus_if.data_out, 32'h0000_0001);
        chk("post_rst_latency", last_evt_cyc - t, 32'd3);

        repeat (3) @(negedge clk);
        if (resp_q.size() != 0 || req_q.size() != 0) fail_now("outstanding_expectations");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
